// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a valid/ready request side and a valid/ready result side.
// Single-cycle ops (AND/OR/ADD/SUB/SLT, zero-length shifts) finish at the
// accept edge. MULU uses an unsigned shift-add loop and SRL/SLL shift one bit
// per cycle. The result stays in DONE until the consumer takes it.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR, OP_ADD, OP_MULU, OP_SRL, OP_SLL, OP_SUB, OP_SLT
  } op_t;

  state_t           state, state_n;
  op_t              op_in, op_q;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [SW-1:0]    cnt, shamt;
  logic             accept, multi;

  assign op_in     = op_t'(op);
  assign shamt     = b[SW-1:0];
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign multi     = (op_in == OP_MULU) ||
                     (((op_in == OP_SRL) || (op_in == OP_SLL)) && (shamt != '0));

  // Single-cycle results and flags, taken straight from the request operands.
  logic [WIDTH:0]   add_full, sub_full;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // Combinational single-cycle datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    case (op_in)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = sub_ovf;
      end
      // Sign of the difference corrected by overflow gives the true signed compare.
      OP_SLT: alu_res = WIDTH'(sub_full[WIDTH-1] ^ sub_ovf);
      // Only reached with a zero shift amount: the operand passes through.
      OP_SRL, OP_SLL: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  // One iteration of the multi-cycle loop on the working registers.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;

  // Next value of the working registers for the current BUSY cycle.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    step_hi = acc_hi;
    step_lo = acc_lo;
    case (op_q)
      OP_MULU: begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
      OP_SRL:  step_lo = acc_lo >> 1;
      OP_SLL:  step_lo = acc_lo << 1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = multi ? BUSY : DONE;
      BUSY: if (cnt == '0) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_AND;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= op_in;
          mcand  <= a;
          acc_hi <= '0;
          if (op_in == OP_MULU) begin
            acc_lo <= b;
            cnt    <= SW'(WIDTH-1);
          end else if (multi) begin
            acc_lo <= a;
            cnt    <= shamt - SW'(1);
          end else begin
            result    <= alu_res;
            result_hi <= '0;
            zero      <= (alu_res == '0);
            cout      <= alu_c;
            overflow  <= alu_v;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == '0) begin
            result    <= step_lo;
            result_hi <= step_hi;
            zero      <= ({step_hi, step_lo} == '0);
            cout      <= 1'b0;
            overflow  <= 1'b0;
          end else begin
            cnt <= cnt - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and random checks of alu_multicycle (WIDTH=32) against an
// arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, zero, cout, overflow;
  logic [W-1:0]  result, result_hi;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from plain arithmetic on the operation's definition.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] ehi, output logic [31:0] elo,
                       output logic ez, output logic ec, output logic ev, output int elat);
    longint sa, sb, sr;
    longint lim_hi, lim_lo;
    logic [63:0] prod;
    int sh;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    sh = int'(mb[4:0]);
    ehi = '0; elo = '0; ec = 1'b0; ev = 1'b0; elat = 1;
    case (mop)
      3'd0: elo = ma & mb;
      3'd1: elo = ma | mb;
      3'd2: begin
        elo = ma + mb;
        ec  = ({32'b0, ma} + {32'b0, mb}) > 64'hFFFF_FFFF;
        sr  = sa + sb;
        ev  = (sr > lim_hi) || (sr < lim_lo);
      end
      3'd3: begin
        prod = {32'b0, ma} * {32'b0, mb};
        ehi  = prod[63:32];
        elo  = prod[31:0];
        elat = W + 1;
      end
      3'd4: begin elo = ma >> sh; elat = (sh == 0) ? 1 : sh + 1; end
      3'd5: begin elo = ma << sh; elat = (sh == 0) ? 1 : sh + 1; end
      3'd6: begin
        elo = ma - mb;
        ec  = (ma >= mb);
        sr  = sa - sb;
        ev  = (sr > lim_hi) || (sr < lim_lo);
      end
      default: elo = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    ez = ({ehi, elo} == 64'd0);
  endtask

  // One full transaction: request, wait for completion, optional hold, handshake.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] ehi, elo;
    logic ez, ec, ev;
    int elat, lat;
    bit rdy_seen;
    model(o, x, y, ehi, elo, ez, ec, ev, elat);
    @(posedge clk); #1;
    check({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    // Operands after acceptance must be ignored.
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    check({tag, " latency"}, lat, elat);
    check({tag, " in_ready busy"}, {rdy_seen, in_ready}, 0);
    check({tag, " result"}, result, elo);
    check({tag, " result_hi"}, result_hi, ehi);
    check({tag, " flags z/c/v"}, {zero, cout, overflow}, {ez, ec, ev});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {out_valid, in_ready, zero, cout, overflow, result_hi, result},
            {1'b1, 1'b0, ez, ec, ev, ehi, elo});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " after take valid/ready"}, {out_valid, in_ready}, 2'b01);
    check({tag, " result held"}, {result_hi, result}, {ehi, elo});
  endtask

  initial begin
    bit pulse;
    // Reset state while rst is high.
    @(posedge clk); #1;
    check("reset in_ready/out_valid", {in_ready, out_valid}, 2'b00);
    check("reset result", {result_hi, result}, 64'd0);
    check("reset flags z/c/v", {zero, cout, overflow}, 3'b100);
    @(negedge clk);
    rst = 1'b0;

    // Directed boundary cases.
    run_op("add_ovf",  3'd2, 32'h7FFF_FFFF, 32'h1, 5);
    run_op("sub_eq",   3'd6, 32'd5, 32'd5, 0);
    run_op("slt_min",  3'd7, 32'h8000_0000, 32'h1, 0);
    run_op("mulu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("sll_31",   3'd5, 32'h1, 32'd31, 0);
    run_op("srl_0",    3'd4, 32'h8000_0000, 32'd0, 0);
    run_op("srl_hib",  3'd4, 32'hDEAD_BEEF, 32'h20, 0);
    run_op("add_carry",3'd2, 32'hFFFF_FFFF, 32'h1, 0);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset valid/ready", {out_valid, in_ready}, 2'b00);
    check("midreset result", {result_hi, result}, 64'd0);
    check("midreset zero", zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) pulse = 1'b1;
    end
    check("midreset no pulse", pulse, 1'b0);
    run_op("and_after_rst", 3'd0, 32'hF0, 32'h3C, 0);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
